datapath_regfile: RTL and testbench

- Register file and operand/write-back muxing stage around the 16-bit function unit.
- Supplies operand buses A and B to the function unit, and writes the unit's result (or external data-in) back into the selected register.
- Latches the function unit's V/C/N/Z outputs into a status register.
- Drives address-out and data-out for the memory interface.

---
 rtl/datapath_pkg.sv | 36 +++
 rtl/datapath_regfile_core.sv | 67 ++++++
 rtl/datapath_regfile.sv | 98 +++++++++
 tb/tb_datapath_regfile.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// Shared constants for the datapath: widths, status flag bit positions and
// the operand/write-back mux encodings used by both the register file stage
// and the function unit.
package datapath_pkg;

  localparam int DATA_W  = 16;
  localparam int REG_CNT = 8;
  localparam int ADDR_W  = 3;

  // Bit positions inside the {V,C,N,Z} status register
  localparam int FLAG_V = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

  // Operand B source
  localparam logic MB_REG   = 1'b0;
  localparam logic MB_CONST = 1'b1;

  // Write-back source
  localparam logic MD_FU   = 1'b0;
  localparam logic MD_DATA = 1'b1;

  // Assemble the status word from the individual function unit outputs
  function automatic logic [3:0] pack_flags(input logic v, input logic c,
                                            input logic n, input logic z);
    logic [3:0] f;
    f         = '0;
    f[FLAG_V] = v;
    f[FLAG_C] = c;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    return f;
  endfunction

endpackage

// File: rtl/datapath_regfile_core.sv
// Register storage with one write port and two combinational read ports.
// Selects that do not name an implemented register read as zero and never
// write. With ZERO_R0 set, R0 is hard-wired to zero.
module datapath_regfile_core #(
  parameter int DATA_W  = datapath_pkg::DATA_W,
  parameter int REG_CNT = datapath_pkg::REG_CNT,
  parameter int ADDR_W  = datapath_pkg::ADDR_W,
  parameter int ZERO_R0 = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_sel,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_a_sel,
  output logic [DATA_W-1:0] rd_a_data,
  input  logic [ADDR_W-1:0] rd_b_sel,
  output logic [DATA_W-1:0] rd_b_data
);

  logic [DATA_W-1:0] regs_q [REG_CNT];
  logic [DATA_W-1:0] regs_d [REG_CNT];

  // Write decode: at most one register takes wr_data, the rest hold
  always_comb begin
    for (int i = 0; i < REG_CNT; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_en && (wr_sel == ADDR_W'(i)) && !((ZERO_R0 != 0) && (i == 0))) begin
        regs_d[i] = wr_data;
      end
    end
  end

  // Read port A: compare-and-select so unimplemented selects fall through to 0
  always_comb begin
    rd_a_data = '0;
    for (int i = 0; i < REG_CNT; i++) begin
      if ((rd_a_sel == ADDR_W'(i)) && !((ZERO_R0 != 0) && (i == 0))) begin
        rd_a_data = regs_q[i];
      end
    end
  end

  // Read port B: same structure as port A
  always_comb begin
    rd_b_data = '0;
    for (int i = 0; i < REG_CNT; i++) begin
      if ((rd_b_sel == ADDR_W'(i)) && !((ZERO_R0 != 0) && (i == 0))) begin
        rd_b_data = regs_q[i];
      end
    end
  end

  // Storage: asynchronous clear, otherwise take the decoded next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_CNT; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < REG_CNT; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

endmodule

// File: rtl/datapath_regfile.sv
// Register file stage around the function unit: operand buses A/B,
// write-back source mux, {V,C,N,Z} status register and memory port aliases.
// Reads are taken from stored state only; there is deliberately no
// write-to-read bypass because the result path loops back through the
// function unit and a bypass would close a combinational loop.
module datapath_regfile #(
  parameter int DATA_W  = datapath_pkg::DATA_W,
  parameter int REG_CNT = datapath_pkg::REG_CNT,
  parameter int ADDR_W  = datapath_pkg::ADDR_W,
  parameter int ZERO_R0 = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] a_sel,
  input  logic [ADDR_W-1:0] b_sel,
  input  logic [ADDR_W-1:0] d_sel,
  input  logic              wr_en,
  input  logic              mb_sel,
  input  logic              md_sel,
  input  logic [DATA_W-1:0] const_in,
  input  logic [DATA_W-1:0] fu_result,
  input  logic [DATA_W-1:0] data_in,
  input  logic              fu_v,
  input  logic              fu_c,
  input  logic              fu_n,
  input  logic              fu_z,
  input  logic              flag_en,
  output logic [DATA_W-1:0] bus_a,
  output logic [DATA_W-1:0] bus_b,
  output logic [DATA_W-1:0] addr_out,
  output logic [DATA_W-1:0] data_out,
  output logic [3:0]        flags
);

  import datapath_pkg::*;

  logic [DATA_W-1:0] wb_data;
  logic [DATA_W-1:0] reg_a;
  logic [DATA_W-1:0] reg_b;
  logic [3:0]        flags_q;
  logic [3:0]        flags_d;

  // Write-back source: function unit result or external data
  always_comb begin
    wb_data = fu_result;
    if (md_sel == MD_DATA) begin
      wb_data = data_in;
    end
  end

  datapath_regfile_core #(
    .DATA_W  (DATA_W),
    .REG_CNT (REG_CNT),
    .ADDR_W  (ADDR_W),
    .ZERO_R0 (ZERO_R0)
  ) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_sel    (d_sel),
    .wr_data   (wb_data),
    .rd_a_sel  (a_sel),
    .rd_a_data (reg_a),
    .rd_b_sel  (b_sel),
    .rd_b_data (reg_b)
  );

  // Operand buses; memory port simply mirrors them
  always_comb begin
    bus_a = reg_a;
    bus_b = reg_b;
    if (mb_sel == MB_CONST) begin
      bus_b = const_in;
    end
    addr_out = bus_a;
    data_out = bus_b;
  end

  // Status register next state: load all four flags together or hold
  always_comb begin
    flags_d = flags_q;
    if (flag_en) begin
      flags_d = pack_flags(fu_v, fu_c, fu_n, fu_z);
    end
  end

  // Status register storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= 4'b0000;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign flags = flags_q;

endmodule

// File: tb/tb_datapath_regfile.sv
// Bench for datapath_regfile. Three instances share one set of inputs:
// plain (ZERO_R0=0), hard-zero R0 (ZERO_R0=1) and a six-register file
// (selects 6 and 7 unimplemented). A behavioural model per instance is
// updated at each rising edge and compared before and after the edge.
module tb_datapath_regfile;

  localparam int W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [2:0]   a_sel, b_sel, d_sel;
  logic         wr_en, mb_sel, md_sel, flag_en;
  logic [W-1:0] const_in, fu_result, data_in;
  logic         fu_v, fu_c, fu_n, fu_z;

  logic [W-1:0] bus_a_o [3];
  logic [W-1:0] bus_b_o [3];
  logic [W-1:0] addr_o  [3];
  logic [W-1:0] dout_o  [3];
  logic [3:0]   flags_o [3];

  datapath_regfile #(.ZERO_R0(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .a_sel(a_sel), .b_sel(b_sel), .d_sel(d_sel),
    .wr_en(wr_en), .mb_sel(mb_sel), .md_sel(md_sel), .const_in(const_in),
    .fu_result(fu_result), .data_in(data_in), .fu_v(fu_v), .fu_c(fu_c),
    .fu_n(fu_n), .fu_z(fu_z), .flag_en(flag_en), .bus_a(bus_a_o[0]),
    .bus_b(bus_b_o[0]), .addr_out(addr_o[0]), .data_out(dout_o[0]),
    .flags(flags_o[0]));

  datapath_regfile #(.ZERO_R0(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .a_sel(a_sel), .b_sel(b_sel), .d_sel(d_sel),
    .wr_en(wr_en), .mb_sel(mb_sel), .md_sel(md_sel), .const_in(const_in),
    .fu_result(fu_result), .data_in(data_in), .fu_v(fu_v), .fu_c(fu_c),
    .fu_n(fu_n), .fu_z(fu_z), .flag_en(flag_en), .bus_a(bus_a_o[1]),
    .bus_b(bus_b_o[1]), .addr_out(addr_o[1]), .data_out(dout_o[1]),
    .flags(flags_o[1]));

  datapath_regfile #(.REG_CNT(6), .ADDR_W(3), .ZERO_R0(0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .a_sel(a_sel), .b_sel(b_sel), .d_sel(d_sel),
    .wr_en(wr_en), .mb_sel(mb_sel), .md_sel(md_sel), .const_in(const_in),
    .fu_result(fu_result), .data_in(data_in), .fu_v(fu_v), .fu_c(fu_c),
    .fu_n(fu_n), .fu_z(fu_z), .flag_en(flag_en), .bus_a(bus_a_o[2]),
    .bus_b(bus_b_o[2]), .addr_out(addr_o[2]), .data_out(dout_o[2]),
    .flags(flags_o[2]));

  // ---------------- reference model ----------------
  logic [W-1:0] mreg [3][8];
  logic [3:0]   mflags;
  logic [W-1:0] exp_q [$];

  int checks = 0;
  int errors = 0;

  function automatic int impl_regs(input int k);
    return (k == 2) ? 6 : 8;
  endfunction

  function automatic logic [W-1:0] mread(input int k, input logic [2:0] sel);
    if (int'(sel) >= impl_regs(k)) return '0;
    if (k == 1 && sel == 3'd0) return '0;
    return mreg[k][sel];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 8; i++) mreg[k][i] = '0;
    mflags = 4'b0000;
  endtask

  // Effect of one rising edge with the current inputs
  task automatic model_edge();
    logic [W-1:0] wd;
    if (!rst_n) return;
    wd = md_sel ? data_in : fu_result;
    if (wr_en) begin
      for (int k = 0; k < 3; k++)
        if (int'(d_sel) < impl_regs(k)) mreg[k][d_sel] = wd;
    end
    if (flag_en) mflags = {fu_v, fu_c, fu_n, fu_z};
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_eq(input string tag, input logic [W-1:0] got,
                          input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    logic [W-1:0] e;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(mread(k, a_sel));
      exp_q.push_back(mb_sel ? const_in : mread(k, b_sel));
      e = exp_q.pop_front();
      check_eq($sformatf("%s bus_a[%0d]", tag, k), bus_a_o[k], e);
      check_eq($sformatf("%s addr_out[%0d]", tag, k), addr_o[k], e);
      e = exp_q.pop_front();
      check_eq($sformatf("%s bus_b[%0d]", tag, k), bus_b_o[k], e);
      check_eq($sformatf("%s data_out[%0d]", tag, k), dout_o[k], e);
      check_eq($sformatf("%s flags[%0d]", tag, k), W'(flags_o[k]), W'(mflags));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    a_sel = 0; b_sel = 0; d_sel = 0; wr_en = 0; mb_sel = 0; md_sel = 0;
    flag_en = 0; const_in = 0; fu_result = 0; data_in = 0;
    fu_v = 0; fu_c = 0; fu_n = 0; fu_z = 0;
  endtask

  // Called just after a falling edge with inputs set: check, edge, check
  task automatic cycle(input string tag);
    #1 check_all({tag, " pre"});
    @(posedge clk);
    model_edge();
    #1 check_all({tag, " post"});
    @(negedge clk);
  endtask

  task automatic write_reg(input logic [2:0] r, input logic [W-1:0] v);
    d_sel = r; wr_en = 1; md_sel = 1; data_in = v;
    cycle("wr");
    wr_en = 0;
  endtask

  task automatic scan_regs(input string tag);
    mb_sel = 0;
    for (int i = 0; i < 8; i++) begin
      a_sel = 3'(i); b_sel = 3'(7 - i);
      #1 check_all(tag);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    drive_idle();
    rst_n = 0;
    model_reset();
    wr_en = 1; d_sel = 5; data_in = 16'hBEEF; md_sel = 1; flag_en = 1; fu_v = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    scan_regs("reset");
    drive_idle();
    rst_n = 1;

    // write/read R5
    a_sel = 5; d_sel = 5; md_sel = 1; data_in = 16'h1234; wr_en = 1;
    #1 check_eq("r5 before edge", bus_a_o[0], 16'h0000);
    @(posedge clk); model_edge();
    #1 check_eq("r5 after edge", bus_a_o[0], 16'h1234);
    check_eq("r5 addr_out", addr_o[0], 16'h1234);
    @(negedge clk); wr_en = 0;

    // read-modify-write R2
    write_reg(3'd2, 16'h00FF);
    a_sel = 2; d_sel = 2; md_sel = 0; fu_result = 16'h0100; wr_en = 1;
    #1 check_eq("rmw before", bus_a_o[0], 16'h00FF);
    @(posedge clk); model_edge();
    #1 check_eq("rmw after", bus_a_o[0], 16'h0100);
    @(negedge clk); wr_en = 0;

    // constant mux
    write_reg(3'd1, 16'hAAAA);
    b_sel = 1; mb_sel = 1; const_in = 16'h0007;
    #1 check_eq("const bus_b", bus_b_o[0], 16'h0007);
    check_eq("const data_out", dout_o[0], 16'h0007);
    mb_sel = 0;
    #1 check_eq("reg bus_b", bus_b_o[0], 16'hAAAA);
    cycle("mux");

    // flags load then hold
    fu_v = 1; fu_c = 1; fu_n = 0; fu_z = 0; flag_en = 1;
    cycle("flag load");
    check_eq("flags 1100", W'(flags_o[0]), W'(4'b1100));
    fu_v = 0; fu_c = 0; fu_n = 1; fu_z = 1; flag_en = 0;
    cycle("flag hold");
    check_eq("flags held", W'(flags_o[0]), W'(4'b1100));

    // R0 write, and write to select 6 (unimplemented in the 6-register file)
    write_reg(3'd0, 16'hFFFF);
    a_sel = 0;
    #1 check_eq("zero_r0 read", bus_a_o[1], 16'h0000);
    check_eq("plain r0 read", bus_a_o[0], 16'hFFFF);
    write_reg(3'd6, 16'h5A5A);
    write_reg(3'd7, 16'hA5A5);
    scan_regs("after r0/oor");

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      a_sel = 3'($urandom_range(0, 7));
      b_sel = 3'($urandom_range(0, 7));
      d_sel = 3'($urandom_range(0, 7));
      wr_en = 1'($urandom_range(0, 1));
      mb_sel = 1'($urandom_range(0, 1));
      md_sel = 1'($urandom_range(0, 1));
      flag_en = 1'($urandom_range(0, 1));
      const_in = W'($urandom);
      fu_result = W'($urandom);
      data_in = W'($urandom);
      {fu_v, fu_c, fu_n, fu_z} = 4'($urandom_range(0, 15));
      if (n % 5 == 0) a_sel = d_sel;
      cycle("rand");
    end

    // reset asserted mid-cycle during a write
    d_sel = 4; wr_en = 1; md_sel = 1; data_in = 16'h7777; flag_en = 1;
    fu_v = 1; fu_c = 1; fu_n = 1; fu_z = 1;
    @(posedge clk); model_edge();
    #2 rst_n = 0;
    model_reset();
    scan_regs("async reset");
    @(posedge clk);
    @(negedge clk);
    scan_regs("reset held");
    rst_n = 1;
    drive_idle();
    cycle("post reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
